// File: rtl/cache_pkg.sv
// Shared constants, flush FSM states and one-hot/index helpers for the cache tag store.
package cache_pkg;

    localparam int unsigned DEF_WAYS     = 4;
    localparam int unsigned DEF_SET_BITS = 3;
    localparam int unsigned SETS         = 1 << DEF_SET_BITS;
    localparam int unsigned WAY_IDX_W    = $clog2(DEF_WAYS);
    localparam int unsigned MAX_WAYS     = 8;
    localparam int unsigned MAX_IDX_W    = 3;

    typedef enum logic [1:0] {
        FL_IDLE  = 2'd0,
        FL_SWEEP = 2'd1,
        FL_DONE  = 2'd2
    } flush_state_e;

    function automatic logic [MAX_WAYS-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
        return MAX_WAYS'(1) << idx;
    endfunction

    // OR-reduce style encoder; only meaningful for a one-hot or zero input.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_WAYS-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_WAYS); i++) begin
            if (oh[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cache_tag_way_bank.sv
// One way of the tag store: per-set tag (not reset), valid and dirty flops, plus the
// read-port compare against the lookup tag.
module cache_tag_way_bank #(
    parameter int unsigned SET_BITS  = 3,
    parameter int unsigned TAG_WIDTH = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [SET_BITS-1:0]  rd_set_i,
    input  logic [TAG_WIDTH-1:0] rd_tag_i,
    input  logic                 fill_en_i,
    input  logic [SET_BITS-1:0]  fill_set_i,
    input  logic [TAG_WIDTH-1:0] fill_tag_i,
    input  logic                 fill_dirty_i,
    input  logic                 mark_en_i,
    input  logic [SET_BITS-1:0]  mark_set_i,
    input  logic                 clr_en_i,
    input  logic [SET_BITS-1:0]  clr_set_i,
    output logic                 match_o,
    output logic                 rd_valid_o,
    output logic                 rd_dirty_o,
    output logic [TAG_WIDTH-1:0] rd_tag_o
);

    localparam int unsigned NSETS = 1 << SET_BITS;

    logic [TAG_WIDTH-1:0] tag_q [NSETS];
    logic [NSETS-1:0]     valid_q, valid_d;
    logic [NSETS-1:0]     dirty_q, dirty_d;

    // Priority per set: sweep clear, then fill, then mark (mark needs a valid line).
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        for (int s = 0; s < int'(NSETS); s++) begin
            if (clr_en_i && (clr_set_i == SET_BITS'(s))) begin
                valid_d[s] = 1'b0;
                dirty_d[s] = 1'b0;
            end else if (fill_en_i && (fill_set_i == SET_BITS'(s))) begin
                valid_d[s] = 1'b1;
                dirty_d[s] = fill_dirty_i;
            end else if (mark_en_i && (mark_set_i == SET_BITS'(s)) && valid_q[s]) begin
                dirty_d[s] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_en_i) tag_q[fill_set_i] <= fill_tag_i;
    end

    assign rd_tag_o   = tag_q[rd_set_i];
    assign rd_valid_o = valid_q[rd_set_i];
    assign rd_dirty_o = dirty_q[rd_set_i];
    assign match_o    = rd_valid_o && (rd_tag_o == rd_tag_i);

endmodule

// File: rtl/cache_tag_way_array.sv
// N-way set-associative tag store: zero-latency hit compare, victim selection
// (first invalid way, else per-set round-robin) and a multi-cycle invalidate-all sweep.
module cache_tag_way_array
    import cache_pkg::*;
#(
    parameter int unsigned WAYS      = DEF_WAYS,
    parameter int unsigned SET_BITS  = DEF_SET_BITS,
    parameter int unsigned TAG_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SET_BITS-1:0]  lookup_set,
    input  logic [TAG_WIDTH-1:0] lookup_tag,
    input  logic                 lookup_valid,
    output logic                 lookup_ready,
    output logic                 hit,
    output logic [WAYS-1:0]      hit_way,
    output logic                 hit_dirty,
    output logic [WAYS-1:0]      victim_way,
    output logic                 victim_valid,
    output logic                 victim_dirty,
    output logic [TAG_WIDTH-1:0] victim_tag,
    input  logic                 fill_en,
    input  logic [SET_BITS-1:0]  fill_set,
    input  logic [WAYS-1:0]      fill_way,
    input  logic [TAG_WIDTH-1:0] fill_tag,
    input  logic                 fill_dirty,
    input  logic                 mark_dirty_en,
    input  logic [SET_BITS-1:0]  mark_set,
    input  logic [WAYS-1:0]      mark_way,
    input  logic                 flush_req,
    output logic                 flush_busy,
    output logic                 flush_done
);

    localparam int unsigned NSETS = 1 << SET_BITS;
    localparam int unsigned RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    flush_state_e         state_q, state_d;
    logic [SET_BITS-1:0]  cnt_q, cnt_d;
    logic [RR_W-1:0]      rr_q [NSETS];
    logic [RR_W-1:0]      rr_d [NSETS];

    logic                 busy;
    logic                 sweep;
    logic                 fill_ok;
    logic                 mark_ok;
    logic [WAYS-1:0]      way_match;
    logic [WAYS-1:0]      way_valid;
    logic [WAYS-1:0]      way_dirty;
    logic [TAG_WIDTH-1:0] way_tag [WAYS];
    logic [RR_W-1:0]      hit_idx;
    logic [RR_W-1:0]      fill_idx;
    logic [RR_W-1:0]      vic_idx;
    logic                 vic_found;

    assign busy    = (state_q != FL_IDLE);
    assign sweep   = (state_q == FL_SWEEP);
    assign fill_ok = fill_en && !busy;
    assign mark_ok = mark_dirty_en && !busy;

    for (genvar w = 0; w < int'(WAYS); w++) begin : g_way
        cache_tag_way_bank #(
            .SET_BITS  (SET_BITS),
            .TAG_WIDTH (TAG_WIDTH)
        ) u_bank (
            .clk_i        (clk),
            .rst_i        (rst),
            .rd_set_i     (lookup_set),
            .rd_tag_i     (lookup_tag),
            .fill_en_i    (fill_ok && fill_way[w]),
            .fill_set_i   (fill_set),
            .fill_tag_i   (fill_tag),
            .fill_dirty_i (fill_dirty),
            .mark_en_i    (mark_ok && mark_way[w]),
            .mark_set_i   (mark_set),
            .clr_en_i     (sweep),
            .clr_set_i    (cnt_q),
            .match_o      (way_match[w]),
            .rd_valid_o   (way_valid[w]),
            .rd_dirty_o   (way_dirty[w]),
            .rd_tag_o     (way_tag[w])
        );
    end

    // Hit path is blanked while the sweep owns the array.
    assign hit_way   = busy ? '0 : way_match;
    assign hit       = |hit_way;
    assign hit_dirty = |(hit_way & way_dirty);
    assign hit_idx   = RR_W'(onehot_to_idx(MAX_WAYS'(way_match)));
    assign fill_idx  = RR_W'(onehot_to_idx(MAX_WAYS'(fill_way)));

    always_comb begin
        vic_idx   = rr_q[lookup_set];
        vic_found = 1'b0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!way_valid[w] && !vic_found) begin
                vic_idx   = RR_W'(w);
                vic_found = 1'b1;
            end
        end
    end

    assign victim_way   = WAYS'(idx_to_onehot(MAX_IDX_W'(vic_idx)));
    assign victim_valid = way_valid[vic_idx];
    assign victim_dirty = way_valid[vic_idx] && way_dirty[vic_idx];
    assign victim_tag   = way_tag[vic_idx];

    // Pointer steps past a way that was just filled or hit, approximating NRU.
    always_comb begin
        for (int s = 0; s < int'(NSETS); s++) begin
            rr_d[s] = rr_q[s];
            if (sweep && (cnt_q == SET_BITS'(s))) begin
                rr_d[s] = '0;
            end else if ((fill_ok && (fill_set == SET_BITS'(s)) && (fill_idx == rr_q[s])) ||
                         (lookup_valid && hit && (lookup_set == SET_BITS'(s)) &&
                          (hit_idx == rr_q[s]))) begin
                rr_d[s] = (rr_q[s] == RR_W'(WAYS - 1)) ? '0 : rr_q[s] + RR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(NSETS); s++) rr_q[s] <= '0;
        end else begin
            for (int s = 0; s < int'(NSETS); s++) rr_q[s] <= rr_d[s];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FL_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FL_IDLE: begin
                if (flush_req) begin
                    state_d = FL_SWEEP;
                    cnt_d   = '0;
                end
            end
            FL_SWEEP: begin
                cnt_d = cnt_q + SET_BITS'(1);
                if (cnt_q == SET_BITS'(NSETS - 1)) state_d = FL_DONE;
            end
            FL_DONE:  state_d = FL_IDLE;
            default:  state_d = FL_IDLE;
        endcase
    end

    assign lookup_ready = !busy;
    assign flush_busy   = busy;
    assign flush_done   = (state_q == FL_DONE);

endmodule

// File: tb/tb_cache_tag_way_array.sv
// Directed plus random bench for cache_tag_way_array against an array-based reference model.
module tb_cache_tag_way_array;

    localparam int WAYS = 4;
    localparam int SB   = 3;
    localparam int TW   = 24;
    localparam int NS   = 8;

    logic            clk;
    logic            rst;
    logic [SB-1:0]   lookup_set;
    logic [TW-1:0]   lookup_tag;
    logic            lookup_valid;
    logic            lookup_ready;
    logic            hit;
    logic [WAYS-1:0] hit_way;
    logic            hit_dirty;
    logic [WAYS-1:0] victim_way;
    logic            victim_valid;
    logic            victim_dirty;
    logic [TW-1:0]   victim_tag;
    logic            fill_en;
    logic [SB-1:0]   fill_set;
    logic [WAYS-1:0] fill_way;
    logic [TW-1:0]   fill_tag;
    logic            fill_dirty;
    logic            mark_dirty_en;
    logic [SB-1:0]   mark_set;
    logic [WAYS-1:0] mark_way;
    logic            flush_req;
    logic            flush_busy;
    logic            flush_done;

    cache_tag_way_array #(.WAYS(WAYS), .SET_BITS(SB), .TAG_WIDTH(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_set   (lookup_set),
        .lookup_tag   (lookup_tag),
        .lookup_valid (lookup_valid),
        .lookup_ready (lookup_ready),
        .hit          (hit),
        .hit_way      (hit_way),
        .hit_dirty    (hit_dirty),
        .victim_way   (victim_way),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .fill_en      (fill_en),
        .fill_set     (fill_set),
        .fill_way     (fill_way),
        .fill_tag     (fill_tag),
        .fill_dirty   (fill_dirty),
        .mark_dirty_en(mark_dirty_en),
        .mark_set     (mark_set),
        .mark_way     (mark_way),
        .flush_req    (flush_req),
        .flush_busy   (flush_busy),
        .flush_done   (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: phase -1 idle, 0..NS-1 sweeping that set, NS done pulse.
    bit          m_valid [NS][WAYS];
    bit          m_dirty [NS][WAYS];
    logic [TW-1:0] m_tag [NS][WAYS];
    int          m_rr    [NS];
    int          m_phase;
    logic [TW-1:0] pool  [8];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
            m_rr[s] = 0;
        end
        m_phase = -1;
    endtask

    function automatic int m_hit(input int s, input logic [TW-1:0] t);
        int h;
        h = -1;
        if (m_phase != -1) return -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && (m_tag[s][w] == t)) h = w;
        return h;
    endfunction

    function automatic int oh_idx(input logic [WAYS-1:0] oh);
        int r;
        r = 0;
        for (int w = 0; w < WAYS; w++) if (oh[w]) r = w;
        return r;
    endfunction

    task automatic check_all(input string tag);
        int s, hi, vi;
        bit busy;
        #1;
        s    = int'(lookup_set);
        busy = (m_phase != -1);
        hi   = m_hit(s, lookup_tag);
        vi   = m_rr[s];
        for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) vi = w;
        chk({tag, ".hit"},       64'(hit),       64'(hi >= 0));
        chk({tag, ".hit_way"},   64'(hit_way),   (hi >= 0) ? (64'd1 << hi) : 64'd0);
        chk({tag, ".hit_dirty"}, 64'(hit_dirty), (hi >= 0) ? 64'(m_dirty[s][hi]) : 64'd0);
        chk({tag, ".hit_1hot"},  64'($onehot0(hit_way)), 64'd1);
        chk({tag, ".vic_way"},   64'(victim_way),   64'd1 << vi);
        chk({tag, ".vic_valid"}, 64'(victim_valid), 64'(m_valid[s][vi]));
        chk({tag, ".vic_dirty"}, 64'(victim_dirty), 64'(m_valid[s][vi] && m_dirty[s][vi]));
        if (m_valid[s][vi]) chk({tag, ".vic_tag"}, 64'(victim_tag), 64'(m_tag[s][vi]));
        chk({tag, ".ready"},     64'(lookup_ready), 64'(!busy));
        chk({tag, ".busy"},      64'(flush_busy),   64'(busy));
        chk({tag, ".done"},      64'(flush_done),   64'(m_phase == NS));
    endtask

    // Advance the model by the rules for one clock edge, then step the clock.
    task automatic tick();
        int  hi, fi, mi;
        bit  adv [NS];
        if (!rst) begin
            if (m_phase == -1) begin
                for (int s = 0; s < NS; s++) adv[s] = 1'b0;
                hi = m_hit(int'(lookup_set), lookup_tag);
                fi = oh_idx(fill_way);
                mi = oh_idx(mark_way);
                if (lookup_valid && hi >= 0 && hi == m_rr[lookup_set]) adv[lookup_set] = 1'b1;
                if (fill_en && fi == m_rr[fill_set]) adv[fill_set] = 1'b1;
                if (mark_dirty_en && m_valid[mark_set][mi]) m_dirty[mark_set][mi] = 1'b1;
                if (fill_en) begin
                    m_valid[fill_set][fi] = 1'b1;
                    m_dirty[fill_set][fi] = fill_dirty;
                    m_tag[fill_set][fi]   = fill_tag;
                end
                for (int s = 0; s < NS; s++) if (adv[s]) m_rr[s] = (m_rr[s] + 1) % WAYS;
                if (flush_req) m_phase = 0;
            end else if (m_phase < NS) begin
                for (int w = 0; w < WAYS; w++) begin
                    m_valid[m_phase][w] = 1'b0;
                    m_dirty[m_phase][w] = 1'b0;
                end
                m_rr[m_phase] = 0;
                m_phase++;
            end else begin
                m_phase = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_fill(input int s, input int w, input logic [TW-1:0] t, input bit d);
        fill_en    = 1'b1;
        fill_set   = SB'(s);
        fill_way   = WAYS'(1 << w);
        fill_tag   = t;
        fill_dirty = d;
    endtask

    initial begin
        int busy_n, done_at, fw, fs;
        logic [TW-1:0] ft;

        rst = 1'b1;
        lookup_set = '0; lookup_tag = '0; lookup_valid = 1'b0;
        fill_en = 1'b0; fill_set = '0; fill_way = 4'b0001; fill_tag = '0; fill_dirty = 1'b0;
        mark_dirty_en = 1'b0; mark_set = '0; mark_way = 4'b0001; flush_req = 1'b0;
        for (int i = 0; i < 8; i++) pool[i] = TW'(24'h100000 + i * 24'h010203);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Post-reset lookup
        lookup_set = 3'd3; lookup_tag = 24'h123456;
        check_all("reset");
        chk("reset.hit_lit", 64'(hit), 64'd0);
        chk("reset.vic_way_lit", 64'(victim_way), 64'b0001);
        chk("reset.vic_valid_lit", 64'(victim_valid), 64'd0);
        chk("reset.ready_lit", 64'(lookup_ready), 64'd1);

        // Fill not visible in its own cycle, visible the next
        do_fill(2, 2, 24'hABCDEF, 1'b0);
        lookup_set = 3'd2; lookup_tag = 24'hABCDEF; lookup_valid = 1'b1;
        check_all("fill_same");
        chk("fill_same.hit_lit", 64'(hit), 64'd0);
        tick();
        fill_en = 1'b0;
        check_all("fill_next");
        chk("fill_next.hit_lit", 64'(hit), 64'd1);
        chk("fill_next.way_lit", 64'(hit_way), 64'b0100);
        lookup_valid = 1'b0;

        // Full set: round-robin victim with a dirtied line
        for (int w = 0; w < WAYS; w++) begin
            do_fill(5, w, TW'(24'h500000 + w), 1'b0);
            tick();
        end
        fill_en = 1'b0;
        mark_dirty_en = 1'b1; mark_set = 3'd5; mark_way = 4'b0001;
        tick();
        mark_dirty_en = 1'b0;
        lookup_set = 3'd5; lookup_tag = 24'h777777;
        check_all("rr_victim");
        chk("rr_victim.way_lit", 64'(victim_way), 64'b0001);
        chk("rr_victim.dirty_lit", 64'(victim_dirty), 64'd1);
        chk("rr_victim.tag_lit", 64'(victim_tag), 64'h500000);

        // Fill beats mark on the same set/way
        do_fill(6, 1, 24'h600001, 1'b1);
        tick();
        do_fill(6, 1, 24'h600002, 1'b0);
        mark_dirty_en = 1'b1; mark_set = 3'd6; mark_way = 4'b0010;
        tick();
        fill_en = 1'b0; mark_dirty_en = 1'b0;
        lookup_set = 3'd6; lookup_tag = 24'h600002;
        check_all("fill_wins");
        chk("fill_wins.dirty_lit", 64'(hit_dirty), 64'd0);

        // Full flush sweep with an ignored fill in the middle
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        busy_n = 0; done_at = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 2) do_fill(1, 0, 24'h111111, 1'b1);
            else fill_en = 1'b0;
            check_all($sformatf("flush%0d", i));
            if (flush_busy === 1'b1) busy_n++;
            if (flush_done === 1'b1) done_at = i;
            tick();
        end
        fill_en = 1'b0;
        chk("flush.busy_cycles", 64'(busy_n), 64'd9);
        chk("flush.done_cycle", 64'(done_at), 64'd9);
        for (int s = 0; s < NS; s++) begin
            lookup_set = SB'(s);
            lookup_tag = (s == 1) ? 24'h111111 : ((s == 5) ? 24'h500001 : 24'hABCDEF);
            check_all($sformatf("post_flush%0d", s));
            chk("post_flush.hit_lit", 64'(hit), 64'd0);
            tick();
        end

        // Reset in the middle of a sweep
        do_fill(3, 3, 24'h333333, 1'b0);
        tick();
        fill_en = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (3) begin
            check_all("pre_rst");
            tick();
        end
        rst = 1'b1;
        model_reset();
        check_all("mid_rst");
        chk("mid_rst.busy_lit", 64'(flush_busy), 64'd0);
        tick();
        rst = 1'b0;
        for (int s = 0; s < NS; s++) begin
            lookup_set = SB'(s); lookup_tag = 24'h333333;
            check_all($sformatf("after_rst%0d", s));
            tick();
        end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_all($sformatf("reflush%0d", i));
            tick();
        end

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            lookup_set   = SB'($urandom_range(0, NS - 1));
            lookup_tag   = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 7)] : TW'($urandom());
            lookup_valid = 1'(($urandom_range(0, 1)));
            fill_en      = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                fs = int'($urandom_range(0, NS - 1));
                fw = int'($urandom_range(0, WAYS - 1));
                ft = pool[$urandom_range(0, 7)];
                for (int w = 0; w < WAYS; w++)
                    if (m_valid[fs][w] && m_tag[fs][w] == ft) fw = w;
                do_fill(fs, fw, ft, 1'(($urandom_range(0, 1))));
            end
            mark_dirty_en = ($urandom_range(0, 4) == 0);
            mark_set      = SB'($urandom_range(0, NS - 1));
            mark_way      = WAYS'(1 << $urandom_range(0, WAYS - 1));
            flush_req     = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1;
                model_reset();
                check_all("rand_rst");
                tick();
                rst = 1'b0;
            end else begin
                check_all("rand");
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_tag_way_array.md
Name: cache_tag_way_array

Overview:
- Parametrised N-way set-associative tag store for the custom_cpu I/D caches.
- Holds tag, valid and dirty per way/set, and does the hit compare across all ways.
- Selects the replacement victim: first invalid way, else a per-set round-robin pointer.
- Provides a multi-cycle invalidate-all sweep for cache flush/fence.
- Sits between the cache controller FSM and the data arrays; replaces the per-way single tag arrays.

Parameters:
- WAYS, 4, number of ways; power of two, 1..8.
- SET_BITS, 3, log2 of set count (8 sets).
- TAG_WIDTH, 24, stored tag width in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- lookup_set  in  SET_BITS  set index for compare.
- lookup_tag  in  TAG_WIDTH  tag to compare.
- lookup_valid  in  1  lookup request; updates the round-robin state only on a hit.
- lookup_ready  out  1  array available; 0 while a flush sweep is running.
- hit  out  1  some valid way of lookup_set matches lookup_tag.
- hit_way  out  WAYS  one-hot matching way.
- hit_dirty  out  1  dirty bit of the hit way.
- victim_way  out  WAYS  one-hot victim for lookup_set.
- victim_valid  out  1  victim way currently valid.
- victim_dirty  out  1  victim way valid and dirty; write-back needed.
- victim_tag  out  TAG_WIDTH  stored tag of the victim, for the write-back address.
- fill_en  in  1  write a new line.
- fill_set  in  SET_BITS  set for fill.
- fill_way  in  WAYS  one-hot way for fill.
- fill_tag  in  TAG_WIDTH  tag written.
- fill_dirty  in  1  initial dirty bit (1 for write-allocate store).
- mark_dirty_en  in  1  set the dirty bit of an existing line.
- mark_set  in  SET_BITS  set for mark.
- mark_way  in  WAYS  one-hot way for mark.
- flush_req  in  1  pulse; start the invalidate-all sweep.
- flush_busy  out  1  sweep in progress.
- flush_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (async, rst=1):
  - all valid, dirty and round-robin pointers clear to 0; FSM goes to IDLE.
  - lookup_ready=1, flush_busy=0, flush_done=0.
  - Tag storage is not reset.
- Read path is combinational, with zero latency:
  - hit, hit_way, hit_dirty and the victim_* outputs follow lookup_set/lookup_tag in the same cycle.
  - Outputs reflect pre-clock-edge state; a fill to the same set in the same cycle is not visible until the next cycle.
- Hit:
  - hit = OR over ways of (valid & tag==lookup_tag).
  - hit_way is the raw match vector; more than one bit set is illegal (bench assertion).
  - hit_dirty = dirty of the matching way, 0 on miss.
- Victim selection:
  - lowest-index invalid way if any way is invalid, otherwise the way at rr_ptr[lookup_set].
  - victim_tag/valid/dirty are taken from that way.
- Fill (fill_en=1, FSM IDLE):
  - at the clock edge: tag<=fill_tag, valid<=1, dirty<=fill_dirty.
  - rr_ptr[fill_set] advances by 1 mod WAYS if the filled way equals the current rr pointer way.
- Mark dirty (mark_dirty_en=1, FSM IDLE, target valid): dirty<=1. Ignored if the target is invalid.
- Simultaneous fill and mark_dirty on the same set/way: fill wins. Different set/way: both take effect.
- Lookup hit with lookup_valid=1: rr_ptr for that set moves past the hit way, if the hit way equals the pointer. This gives approximate not-recently-used replacement.
- Flush FSM, states IDLE, SWEEP, DONE:
  - IDLE -> SWEEP on flush_req; the sweep counter cnt is set to 0.
  - SWEEP: clear valid/dirty of every way in set cnt and clear rr_ptr[cnt]; cnt++.
  - After set 2^SET_BITS-1, go to DONE. A sweep takes exactly 2^SET_BITS cycles.
  - DONE: flush_done=1 for one cycle, then IDLE.
  - flush_busy=1 in SWEEP and DONE; lookup_ready=~flush_busy.
  - While busy: hit forced to 0; fill_en and mark_dirty_en ignored; flush_req ignored (no restart).
  - Flush is invalidate only; dirty write-back before a flush is the controller's responsibility.
- Reset asserted mid-sweep: immediate IDLE, all valid cleared, no flush_done pulse.
- A fill_way or mark_way that is not one-hot is illegal; behaviour is undefined; bench assertion.

Decomposition:
- Shared package cache_pkg holds:
  - the derived constants SETS=1<<SET_BITS and WAY_IDX_W=$clog2(WAYS);
  - the flush state enum;
  - onehot<->index conversion functions.
- One natural sub-module, cache_tag_way_bank: one way's tag storage plus per-set valid/dirty flops, async clear, and a match output. It is instantiated WAYS times with a generate loop.
- Victim select, rr_ptr and the flush FSM stay in the top module.

Test Plan:
- Reset, then lookup set 3 with any tag -> hit=0, victim_way=4'b0001, victim_valid=0, lookup_ready=1.
- Fill set 2 way 4'b0100 with tag 0xABCDEF, dirty=0; next cycle lookup (2, 0xABCDEF) -> hit=1, hit_way=4'b0100, hit_dirty=0. Same cycle as the fill -> hit=0.
- Fill all 4 ways of set 5; mark_dirty way 4'b0001; then lookup a missing tag -> victim_way=rr way 4'b0001, victim_dirty=1, victim_tag = the tag stored in way 0 of set 5.
- Fill and mark_dirty on the same set/way in the same cycle with fill_dirty=0 -> dirty=0 afterwards (fill wins).
- Populate several sets, pulse flush_req -> flush_busy high for 9 cycles (8 sweep + DONE), flush_done pulses in the 9th cycle, and a fill during the sweep is ignored. Afterwards every lookup returns hit=0.
- Assert rst at sweep cycle 4 -> flush_busy=0 immediately, no flush_done, all sets invalid, and a new flush_req is accepted normally.
